csa_accumulator: RTL
====================

# csa_accumulator

Parametrised carry-save accumulator for the PE datapath, the multi-cycle successor to the single-level 3:2 compressor. Each accepted beat delivers up to M operands of N bits. The block folds them, together with its registered sum/carry pair, through a chain of 3:2 compression levels. The carry-propagate add is deferred to a single resolve cycle at packet end, and the modulo-2^N total is presented on a valid/ready output.

## Interface
- N, 64, operand and result width in bits.
- M, 4, operands per input beat (M ≥ 1).
- CNT_W, 16, width of the beat counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous abort; empties the accumulator and returns to ACC.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_data  input  M*N  operand k occupies bits [k*N +: N].
- in_keep  input  M  operand k is summed only if in_keep[k]=1; otherwise it is treated as 0.
- in_last  input  1  final beat of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  N  packet sum mod 2^N.
- out_beats  output  CNT_W  number of beats in the reported packet, saturating.

## Operation
- State registers: sum_q[N], carry_q[N], beat_cnt[CNT_W], res_q[N], and a state field with states ACC, RES and OUT.
- Per-beat reduction, combinational:
  - Start from (s, c) = (sum_q, carry_q).
  - For k = 0..M-1, apply one 3:2 level: s' = s ^ c ^ x_k, and c' = majority(s, c, x_k) << 1, with the MSB dropped.
  - x_k = in_keep[k] ? operand k : 0.
  - Every quantity is N bits; all arithmetic is mod 2^N.
- ACC:
  - in_ready = 1.
  - On an accepted beat: sum_q/carry_q take the reduced value, and beat_cnt increments, saturating at 2^CNT_W-1.
  - If in_last is set on that beat, go to RES.
  - A beat with in_keep = 0 still counts and may carry in_last.
- RES:
  - in_ready = 0.
  - One cycle: res_q ← sum_q + carry_q (N-bit, carry-out discarded). Then go to OUT.
- OUT:
  - out_valid = 1, out_data = res_q, out_beats = beat_cnt.
  - Both outputs hold stable until the handshake.
  - On handshake: sum_q, carry_q and beat_cnt all ← 0, and the state returns to ACC.
  - in_ready = 0 throughout OUT.
- clear:
  - Effect in any state: sum_q, carry_q and beat_cnt ← 0, state ← ACC, out_valid drops the next cycle.
  - Any beat or output handshake in the same cycle is discarded.
- Priority: rst_n low > clear > normal operation.
- Reset values: state ACC, in_ready 1 the cycle after reset, out_valid 0, out_data 0, out_beats 0, and all internal registers 0.

## Timing
- Input throughput is one beat per cycle within a packet.
- Last beat accepted at edge t: RES occupies cycle t+1, and out_valid is asserted at edge t+2.
- Output handshake at edge u: in_ready is 1 again from u, so the next beat can be accepted at edge u+1.
- Minimum packet-to-packet gap is therefore 2 cycles plus any output stall.
- in_ready depends only on state; it never combinationally depends on in_valid.
- The output path is fully registered. The critical path is M compression levels plus the input mux.
- Reset or clear asserted mid-packet or mid-output loses the partial sum. No out_valid is produced for that packet.
- Single-beat packet (in_last on the first beat) is legal: out_beats = 1.

## Test plan
- N=64, M=4: one beat with operands 1, 2, 3, 4, keep=4'hF, last=1. Required: out_data=10 and out_beats=1 at edge t+2.
- N=8, M=2: beats (0xFF, 0x01) then (0x80, 0x80, last). Required: out_data=0x00 (wrap-around) and out_beats=2.
- N=16, M=4: keep=4'b0101 with operands 0x0001, 0xFFFF, 0x0002, 0xFFFF. Required: out_data=0x0003.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_data/out_beats stable, in_ready=0, and no beat accepted. After release, a new packet gives an independent sum.
- clear asserted after 3 beats of a 5-beat packet, then a fresh 2-beat packet summing to 7. Required: exactly one out_valid, with out_data=7 and out_beats=2.
- CNT_W=2: 6-beat packet of all-ones operands. Required: out_beats saturates at 3 and out_data is correct mod 2^N. Repeat with rst_n pulsed low mid-packet; required: all outputs are at their reset values the next cycle.

Source files
------------

// File: rtl/csa_accumulator.sv
// Carry-save packet accumulator: folds M operands per beat into a redundant sum/carry pair
// and resolves the packet total with one carry-propagate add before presenting it.
module csa_accumulator #(
  parameter int N     = 64,
  parameter int M     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M*N-1:0]   in_data,
  input  logic [M-1:0]     in_keep,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid are decoded from the registered state only, so neither
  // depends combinationally on the partner's valid/ready.

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RES = 2'd1,
    OUT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     sum_q, sum_d;
  logic [N-1:0]     carry_q, carry_d;
  logic [N-1:0]     res_q, res_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             in_fire;
  logic             out_fire;

  // Compression chain: level k folds operand k into the running (s, c) pair.
  logic [N-1:0] lvl_s [0:M];
  logic [N-1:0] lvl_c [0:M];

  assign lvl_s[0] = sum_q;
  assign lvl_c[0] = carry_q;

  for (genvar k = 0; k < M; k++) begin : g_level
    logic [N-1:0] x_k;
    logic [N-1:0] maj_k;

    assign x_k           = in_keep[k] ? in_data[k*N +: N] : '0;
    assign maj_k         = (lvl_s[k] & lvl_c[k]) | (lvl_s[k] & x_k) | (lvl_c[k] & x_k);
    assign lvl_s[k+1]    = lvl_s[k] ^ lvl_c[k] ^ x_k;
    assign lvl_c[k+1]    = maj_k << 1;
  end

  assign in_ready    = (state_q == ACC);
  assign out_valid   = (state_q == OUT);
  assign out_data    = res_q;
  assign out_beats   = beat_cnt_q;
  assign dbg_state_o = state_q;

  assign in_fire  = in_valid && in_ready && !clear;
  assign out_fire = out_valid && out_ready && !clear;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    res_d      = res_q;
    beat_cnt_d = beat_cnt_q;

    if (clear) begin
      state_d    = ACC;
      sum_d      = '0;
      carry_d    = '0;
      res_d      = '0;
      beat_cnt_d = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_fire) begin
            sum_d   = lvl_s[M];
            carry_d = lvl_c[M];
            if (beat_cnt_q != {CNT_W{1'b1}}) begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
            if (in_last) begin
              state_d = RES;
            end
          end
        end
        RES: begin
          res_d   = sum_q + carry_q;
          state_d = OUT;
        end
        OUT: begin
          if (out_fire) begin
            sum_d      = '0;
            carry_d    = '0;
            beat_cnt_d = '0;
            state_d    = ACC;
          end
        end
        default: begin
          state_d = ACC;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACC;
      sum_q      <= '0;
      carry_q    <= '0;
      res_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      res_q      <= res_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
